// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: per-cycle latch en/flush/freeze and PC enable,
// resolving dmem wait, halt, EX redirect, load-use and imem miss in fixed priority. Also keeps
// halt status, a data-stall watchdog and saturating stall/flush counters.
module hazard_ctrl #(
   parameter int unsigned CNT_W          = 32,
   parameter int unsigned DSTALL_TIMEOUT = 1024
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             mem_ren,
   input  logic             mem_wen,
   input  logic             mem_halt,
   input  logic             ex_redirect,
   input  logic             ex_memread,
   input  logic [4:0]       ex_rd,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             ifid_freeze,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             idex_freeze,
   output logic             exmem_en,
   output logic             exmem_flush,
   output logic             exmem_freeze,
   output logic             memwb_en,
   output logic             memwb_flush,
   output logic             memwb_freeze,
   output logic             halt,
   output logic             dstall_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {StRun, StDstall, StHalted} state_e;

   // Per-latch control encoding {en, flush, freeze}
   localparam logic [2:0] CtlEn = 3'b100;
   localparam logic [2:0] CtlFl = 3'b010;
   localparam logic [2:0] CtlFz = 3'b001;

   localparam int unsigned WdW = $clog2(DSTALL_TIMEOUT + 1);

   state_e           state_q, state_d;
   logic             halt_q, halt_d;
   logic             err_q, err_d;
   logic [WdW-1:0]   wd_q, wd_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;

   logic       dstall, load_use;
   logic       pc_c;
   logic [2:0] ifid_c, idex_c, exmem_c, memwb_c;

   assign dstall   = (mem_ren | mem_wen) & ~dhit;
   assign load_use = ex_memread & (ex_rd != 5'd0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

   // Zero-latency latch controls from current state and inputs
   always_comb begin
      pc_c    = 1'b0;
      ifid_c  = 3'b000;
      idex_c  = 3'b000;
      exmem_c = 3'b000;
      memwb_c = 3'b000;
      if (!nRST) begin
         // all controls held low while in reset
      end else if (state_q == StHalted || dstall) begin
         {ifid_c, idex_c, exmem_c, memwb_c} = {CtlFz, CtlFz, CtlFz, CtlFz};
      end else if (mem_halt) begin
         {ifid_c, idex_c, exmem_c, memwb_c} = {CtlFz, CtlFz, CtlFz, CtlEn};
      end else if (ex_redirect) begin
         pc_c = 1'b1;
         {ifid_c, idex_c, exmem_c, memwb_c} = {CtlFl, CtlFl, CtlEn, CtlEn};
      end else if (load_use) begin
         {ifid_c, idex_c, exmem_c, memwb_c} = {CtlFz, CtlFl, CtlEn, CtlEn};
      end else if (!ihit) begin
         {ifid_c, idex_c, exmem_c, memwb_c} = {CtlFl, CtlEn, CtlEn, CtlEn};
      end else begin
         pc_c = 1'b1;
         {ifid_c, idex_c, exmem_c, memwb_c} = {CtlEn, CtlEn, CtlEn, CtlEn};
      end
   end

   // Next state, status and saturating counters; HALTED holds everything until reset
   always_comb begin
      state_d = state_q;
      halt_d  = halt_q;
      err_d   = err_q;
      wd_d    = wd_q;
      stall_d = stall_q;
      flush_d = flush_q;
      if (state_q != StHalted) begin
         if (dstall) begin
            state_d = StDstall;
            stall_d = (&stall_q) ? stall_q : stall_q + 1'b1;
            wd_d    = (wd_q == WdW'(DSTALL_TIMEOUT)) ? wd_q : wd_q + 1'b1;
            err_d   = err_q | (wd_d == WdW'(DSTALL_TIMEOUT));
         end else begin
            state_d = StRun;
            wd_d    = '0;
            if (mem_halt) begin
               state_d = StHalted;
               halt_d  = 1'b1;
            end else if (ex_redirect) begin
               flush_d = (&flush_q) ? flush_q : flush_q + 1'b1;
            end else if (load_use || !ihit) begin
               stall_d = (&stall_q) ? stall_q : stall_q + 1'b1;
            end
         end
      end
   end

   // State and status registers, cleared asynchronously by nRST
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= StRun;
         halt_q  <= 1'b0;
         err_q   <= 1'b0;
         wd_q    <= '0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         halt_q  <= halt_d;
         err_q   <= err_d;
         wd_q    <= wd_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign pc_en = pc_c;
   assign {ifid_en, ifid_flush, ifid_freeze}    = ifid_c;
   assign {idex_en, idex_flush, idex_freeze}    = idex_c;
   assign {exmem_en, exmem_flush, exmem_freeze} = exmem_c;
   assign {memwb_en, memwb_flush, memwb_freeze} = memwb_c;
   assign halt       = halt_q;
   assign dstall_err = err_q;
   assign stall_cnt  = stall_q;
   assign flush_cnt  = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver pushes hand-computed expectations, a negedge monitor
// pops and compares.
module tb_hazard_ctrl;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        ihit = 1'b0, dhit = 1'b0, mem_ren = 1'b0, mem_wen = 1'b0;
   logic        mem_halt = 1'b0, ex_redirect = 1'b0, ex_memread = 1'b0;
   logic [4:0]  ex_rd = 5'd0, id_rs1 = 5'd0, id_rs2 = 5'd0;
   logic        pc_en, halt, dstall_err;
   logic        ifid_en, ifid_flush, ifid_freeze, idex_en, idex_flush, idex_freeze;
   logic        exmem_en, exmem_flush, exmem_freeze, memwb_en, memwb_flush, memwb_freeze;
   logic [31:0] stall_cnt, flush_cnt;

   // {pc_en, ifid, idex, exmem, memwb}, each latch {en, flush, freeze}
   localparam logic [12:0] CRst = 13'b0_000_000_000_000;
   localparam logic [12:0] CRun = 13'b1_100_100_100_100;
   localparam logic [12:0] CFrz = 13'b0_001_001_001_001;
   localparam logic [12:0] CHlt = 13'b0_001_001_001_100;
   localparam logic [12:0] CRdr = 13'b1_010_010_100_100;
   localparam logic [12:0] CLu  = 13'b0_001_010_100_100;
   localparam logic [12:0] CMis = 13'b0_010_100_100_100;

   typedef struct {
      string       nm;
      logic [12:0] ctrl;
      logic        h;
      logic        e;
      logic [31:0] sc;
      logic [31:0] fc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   hazard_ctrl #(.CNT_W(32), .DSTALL_TIMEOUT(4)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_ren(mem_ren), .mem_wen(mem_wen),
      .mem_halt(mem_halt), .ex_redirect(ex_redirect), .ex_memread(ex_memread), .ex_rd(ex_rd),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .pc_en(pc_en),
      .ifid_en(ifid_en), .ifid_flush(ifid_flush), .ifid_freeze(ifid_freeze),
      .idex_en(idex_en), .idex_flush(idex_flush), .idex_freeze(idex_freeze),
      .exmem_en(exmem_en), .exmem_flush(exmem_flush), .exmem_freeze(exmem_freeze),
      .memwb_en(memwb_en), .memwb_flush(memwb_flush), .memwb_freeze(memwb_freeze),
      .halt(halt), .dstall_err(dstall_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 CLK = ~CLK;

   // Monitor: every negedge with a pending expectation, compare all outputs
   always @(negedge CLK) begin
      if (sb.size() > 0) begin
         exp_t        x;
         logic [12:0] act;
         x   = sb.pop_front();
         act = {pc_en, ifid_en, ifid_flush, ifid_freeze, idex_en, idex_flush, idex_freeze,
                exmem_en, exmem_flush, exmem_freeze, memwb_en, memwb_flush, memwb_freeze};
         checks++;
         if (act !== x.ctrl || halt !== x.h || dstall_err !== x.e ||
             stall_cnt !== x.sc || flush_cnt !== x.fc) begin
            failures++;
            $display("FAIL %s: got ctrl=%b halt=%b err=%b stall=%0d flush=%0d, want ctrl=%b halt=%b err=%b stall=%0d flush=%0d",
                     x.nm, act, halt, dstall_err, stall_cnt, flush_cnt,
                     x.ctrl, x.h, x.e, x.sc, x.fc);
         end
      end
   end

   // Drive one cycle of inputs and queue the expected response for that cycle
   task automatic step(input string nm, input logic rn, input logic ih, input logic dh,
                       input logic rr, input logic ww, input logic mh, input logic rd,
                       input logic mr, input logic [4:0] erd, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [12:0] c, input logic h,
                       input logic e, input int unsigned sc, input int unsigned fc);
      exp_t x;
      @(posedge CLK);
      #1;
      nRST = rn; ihit = ih; dhit = dh; mem_ren = rr; mem_wen = ww; mem_halt = mh;
      ex_redirect = rd; ex_memread = mr; ex_rd = erd; id_rs1 = r1; id_rs2 = r2;
      x.nm = nm; x.ctrl = c; x.h = h; x.e = e; x.sc = sc; x.fc = fc;
      sb.push_back(x);
   endtask

   task automatic norm(input string nm, input logic h, input logic e, input int unsigned sc,
                       input int unsigned fc);
      step(nm, 1, 1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, CRun, h, e, sc, fc);
   endtask

   initial begin
      // In reset: everything low even with a stalling request present
      step("reset", 0, 1, 0, 1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, CRst, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) norm("run", 0, 0, 0, 0);
      // Data stall for three cycles, then dhit
      for (int i = 0; i < 3; i++)
         step("dstall", 1, 1, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, CFrz, 0, 0, i, 0);
      step("dhit", 1, 1, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, CRun, 0, 0, 3, 0);
      norm("after_dstall", 0, 0, 3, 0);
      // Load-use on rs2, then on rs1
      step("lu_rs2", 1, 1, 0, 0, 0, 0, 0, 1, 5'd5, 5'd0, 5'd5, CLu, 0, 0, 3, 0);
      step("lu_rs1", 1, 1, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd1, CLu, 0, 0, 4, 0);
      // x0 destination is never a hazard
      step("lu_x0", 1, 1, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, CRun, 0, 0, 5, 0);
      // Redirect beats load-use and imem miss
      step("redir_prio", 1, 0, 0, 0, 0, 0, 1, 1, 5'd5, 5'd0, 5'd5, CRdr, 0, 0, 5, 0);
      step("imiss", 1, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, CMis, 0, 0, 5, 1);
      norm("after_miss", 0, 0, 6, 1);
      // Redirect held through a data stall is applied on dhit
      step("redir_dstall", 1, 1, 0, 1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, CFrz, 0, 0, 6, 1);
      step("redir_dhit", 1, 1, 1, 1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, CRdr, 0, 0, 7, 1);
      norm("after_redir", 0, 0, 7, 2);
      // Halt beats redirect, then inputs are ignored
      step("halt", 1, 1, 0, 0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, CHlt, 0, 0, 7, 2);
      for (int i = 0; i < 10; i++)
         step("halted", 1, i[0], 0, 0, 0, 0, ~i[0], 1, 5'd3, 5'd3, 5'd0, CFrz, 1, 0, 7, 2);
      // Async reset pulse clears halt and counters immediately
      step("reset_halt", 0, 1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, CRst, 0, 0, 0, 0);
      norm("run_after_rst", 0, 0, 0, 0);
      // Watchdog: six write-stall cycles with timeout 4
      for (int i = 0; i < 6; i++)
         step("wdog", 1, 1, 0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, CFrz, 0, (i >= 4), i, 0);
      step("wdog_dhit", 1, 1, 1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, CRun, 0, 1, 6, 0);
      norm("wdog_sticky", 0, 1, 6, 0);

      // Bounded drain of the scoreboard
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge CLK);
      @(posedge CLK);
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain: got pending=%0d, want pending=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core.
- Each cycle it generates the en/flush/freeze controls for the IF/ID, ID/EX, EX/MEM and MEM/WB latches, plus the PC write enable.
- It resolves data-memory wait, halt, EX-stage redirect, load-use hazard and instruction-memory miss in a fixed priority.
- It tracks halt state, data-stall watchdog and performance counters.

Parameters:
- CNT_W, 32, width of the saturating stall and flush counters.
- DSTALL_TIMEOUT, 1024, number of consecutive data-stall cycles that sets dstall_err.

Ports:
- CLK  input  1  clock
- nRST  input  1  asynchronous active-low reset
- ihit  input  1  instruction memory returned valid instruction this cycle
- dhit  input  1  data memory completed MEM-stage access this cycle
- mem_ren  input  1  MEM-stage instruction reads dmem
- mem_wen  input  1  MEM-stage instruction writes dmem
- mem_halt  input  1  halt instruction in MEM stage
- ex_redirect  input  1  EX stage resolved taken branch/jump or mispredict; PC input holds target
- ex_memread  input  1  EX-stage instruction is a load
- ex_rd  input  5  EX-stage destination register
- id_rs1  input  5  ID-stage source register 1
- id_rs2  input  5  ID-stage source register 2
- pc_en  output  1  PC register loads next value
- ifid_en, ifid_flush, ifid_freeze  output  1 each  IF/ID latch controls
- idex_en, idex_flush, idex_freeze  output  1 each  ID/EX latch controls
- exmem_en, exmem_flush, exmem_freeze  output  1 each  EX/MEM latch controls
- memwb_en, memwb_flush, memwb_freeze  output  1 each  MEM/WB latch controls
- halt  output  1  core halted (sticky)
- dstall_err  output  1  data-stall watchdog expired (sticky)
- stall_cnt  output  CNT_W  cycles lost to stalls
- flush_cnt  output  CNT_W  redirect flush events

Behaviour:
- FSM states: RUN, DSTALL, HALTED. Reset state is RUN.
- Reset values: halt=0, dstall_err=0, stall_cnt=0, flush_cnt=0, watchdog count=0.
- While nRST is low, every latch control and pc_en is driven 0.
- Latch controls and pc_en are combinational from current inputs and state; there is zero-cycle latency.
- Counters, halt and dstall_err update on the CLK rising edge.
- Invariant outside reset: exactly one of en/flush/freeze is 1 per latch every cycle.
- Priority in RUN/DSTALL (first match wins):
  1. dstall = (mem_ren|mem_wen)&!dhit:
     - all four latches freeze; pc_en=0.
     - Next state DSTALL; stall_cnt+1.
  2. mem_halt:
     - memwb_en=1; IF/ID, ID/EX and EX/MEM freeze; pc_en=0.
     - Next state HALTED.
  3. ex_redirect:
     - pc_en=1; ifid_flush=1, idex_flush=1; exmem_en=1, memwb_en=1.
     - flush_cnt+1.
  4. Load-use: ex_memread & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2):
     - pc_en=0; ifid_freeze=1, idex_flush=1 (bubble); exmem_en=1, memwb_en=1.
     - stall_cnt+1.
  5. !ihit:
     - pc_en=0; ifid_flush=1 (bubble); idex_en, exmem_en, memwb_en=1.
     - stall_cnt+1.
  6. Otherwise: all latch en=1; pc_en=1.
- DSTALL state:
  - Applies the same priority table.
  - Returns to RUN on the first cycle dstall is false; that cycle's outputs follow rules 2-6.
  - The watchdog counts consecutive DSTALL cycles and clears on exit.
  - On reaching DSTALL_TIMEOUT it sets dstall_err. This is status only; control is unaffected.
- HALTED state:
  - All latches freeze; pc_en=0; halt=1.
  - Inputs are ignored; only nRST exits.
- Counters saturate at all-ones.
- A redirect during dstall is not lost: EX is frozen, so ex_redirect is held and applied on dhit.
- Reset asserted mid-stall or in HALTED returns immediately to RUN with all registered outputs cleared.

Test Plan:
- Reset, then ihit=1 and all other inputs 0 for 5 cycles -> every en=1, pc_en=1, stall_cnt=0, flush_cnt=0.
- mem_ren=1, dhit=0 for 3 cycles, then dhit=1 -> all freeze and pc_en=0 for 3 cycles; all en=1 on 4th cycle; stall_cnt=3.
- ex_memread=1, ex_rd=5, id_rs2=5 -> ifid_freeze=1, idex_flush=1, pc_en=0, stall_cnt+1.
- Same stimulus with ex_rd=0 -> normal advance.
- ex_redirect=1 together with load-use and ihit=0 -> redirect wins: ifid_flush=1, idex_flush=1, pc_en=1, flush_cnt=1, stall_cnt unchanged.
- mem_halt=1 for one cycle -> memwb_en=1 that cycle; afterwards halt=1, all freeze for 10 cycles despite ihit/redirect toggling; nRST pulse clears halt.
- DSTALL_TIMEOUT=4, mem_wen=1, dhit=0 for 6 cycles -> dstall_err rises after 4th stall cycle and stays 1 after dhit; stall_cnt=6.
